// File: rtl/digct_event_capture.sv
// Event capture for the registered 3-bit output stage: samples IN_VEC on
// enabled clocks, turns every bit change into a timestamped record and queues
// it in a first-word fall-through FIFO drained by a valid/ready handshake.
module digct_event_capture #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [2:0]               IN_VEC,
  output logic [CNT_W+6-1:0]       OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  input  logic                     CLR_OVF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = CNT_W + 6;

  logic [2:0]       prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [CNT_W-1:0] ts_q, ts_d;
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];

  logic          empty, full;
  logic          push_req, push, pop, drop;
  logic [DW-1:0] rec;

  // Pointer-MSB full/empty detection and record assembly.
  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    push_req = EN && primed_q && (IN_VEC != prev_q);
    pop      = !empty && OUT_READY;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    rec      = {ts_q, IN_VEC ^ prev_q, IN_VEC};
  end

  // Next-state for sampler, timestamp, pointers and sticky overflow.
  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    ts_d     = ts_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ovf_d    = ovf_q;
    if (EN) begin
      prev_d   = IN_VEC;
      primed_d = 1'b1;
      ts_d     = ts_q + CNT_W'(1);
    end
    if (push) wr_d = wr_q + (AW+1)'(1);
    if (pop)  rd_d = rd_q + (AW+1)'(1);
    // Setting wins over clearing.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // Storage next-state: only the tail slot changes, and only on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = rec;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q   <= 3'b000;
      primed_q <= 1'b0;
      ts_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      ts_q     <= ts_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  // Registered-state outputs; the head entry falls through to OUT_DATA.
  always_comb begin
    OUT_DATA  = mem_q[rd_q[AW-1:0]];
    OUT_VALID = !empty;
    LEVEL     = wr_q - rd_q;
    OVF       = ovf_q;
  end

endmodule
